// File: rtl/dual_lane_issuer.sv
// Dual-lane issue source: per-lane sequenced beats that hold under stall,
// with a single mid-run flush per lane that rewinds and replays in-flight items.

module dual_lane_issuer_lane #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_ITEMS  = 8,
    parameter logic [DATA_W-1:0] BASE       = '0,
    parameter int                FLUSH_AT   = 0,
    parameter int                PIPE_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go_i,
    input  logic              stall_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              flush_o,
    output logic [15:0]       cnt_o,
    output logic              idle_o,
    output logic              done_nxt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX  = 8'(NUM_ITEMS - 1);
    localparam logic [7:0] FLUSH_IDX = 8'(FLUSH_AT);
    localparam bit         FLUSH_EN  = (FLUSH_AT != 0) && (FLUSH_AT < NUM_ITEMS);
    localparam logic [8:0] REWIND    = (PIPE_DEPTH > 255) ? 9'd255 : 9'(PIPE_DEPTH);

    state_t            state_q, state_d;
    logic [7:0]        seq_q, seq_d, seq_inc;
    logic [15:0]       cnt_q, cnt_d;
    logic              flushed_q, flushed_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;

    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        flushed_d = flushed_q;
        seq_inc   = seq_q + 8'd1;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go_i) begin
                    state_d   = S_ISSUE;
                    seq_d     = '0;
                    cnt_d     = '0;
                    flushed_d = 1'b0;
                end
            end
            S_ISSUE: begin
                if (!stall_i) begin
                    seq_d = seq_inc;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    // Flush check wins over completion so the rewind still happens at the end.
                    if (FLUSH_EN && !flushed_q && (seq_inc == FLUSH_IDX)) begin
                        state_d = S_FLUSH;
                    end else if (seq_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                state_d   = S_ISSUE;
                flushed_d = 1'b1;
                if ({1'b0, seq_q} >= REWIND) seq_d = seq_q - REWIND[7:0];
                else                         seq_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_ISSUE);
        flush_d = (state_d == S_FLUSH);
        data_d  = valid_d ? (BASE + DATA_W'(seq_d)) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            seq_q     <= '0;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            flushed_q <= flushed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            flush_q   <= flush_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign flush_o    = flush_q;
    assign cnt_o      = cnt_q;
    assign idle_o     = (state_q == S_IDLE) || (state_q == S_DONE);
    assign done_nxt_o = (state_d == S_DONE);

endmodule

module dual_lane_issuer #(
    parameter int                DATA_W     = 32,
    parameter int                NUM_ITEMS  = 8,
    parameter logic [DATA_W-1:0] BASE_1     = DATA_W'(32'h1000_0000),
    parameter logic [DATA_W-1:0] BASE_2     = DATA_W'(32'h2000_0000),
    parameter int                FLUSH_AT   = 0,
    parameter int                PIPE_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall_1,
    input  logic              stall_2,
    output logic [DATA_W-1:0] pipeline1_inputs,
    output logic [DATA_W-1:0] pipeline2_inputs,
    output logic [1:0]        in_valid,
    output logic              flush_1,
    output logic              flush_2,
    output logic              done,
    output logic [15:0]       accept_cnt_1,
    output logic [15:0]       accept_cnt_2
);

    logic idle_1, idle_2, done_nxt_1, done_nxt_2, go;
    logic done_q;

    // A run may only start when neither lane is mid-sequence.
    assign go = start && idle_1 && idle_2;

    dual_lane_issuer_lane #(
        .DATA_W(DATA_W), .NUM_ITEMS(NUM_ITEMS), .BASE(BASE_1),
        .FLUSH_AT(FLUSH_AT), .PIPE_DEPTH(PIPE_DEPTH)
    ) u_lane_1 (
        .clk(clk), .reset(reset), .go_i(go), .stall_i(stall_1),
        .data_o(pipeline1_inputs), .valid_o(in_valid[0]), .flush_o(flush_1),
        .cnt_o(accept_cnt_1), .idle_o(idle_1), .done_nxt_o(done_nxt_1)
    );

    dual_lane_issuer_lane #(
        .DATA_W(DATA_W), .NUM_ITEMS(NUM_ITEMS), .BASE(BASE_2),
        .FLUSH_AT(FLUSH_AT), .PIPE_DEPTH(PIPE_DEPTH)
    ) u_lane_2 (
        .clk(clk), .reset(reset), .go_i(go), .stall_i(stall_2),
        .data_o(pipeline2_inputs), .valid_o(in_valid[1]), .flush_o(flush_2),
        .cnt_o(accept_cnt_2), .idle_o(idle_2), .done_nxt_o(done_nxt_2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) done_q <= 1'b0;
        else        done_q <= done_nxt_1 && done_nxt_2;
    end

    assign done = done_q;

endmodule

// File: tb/tb_dual_lane_issuer.sv
// Scoreboard bench for dual_lane_issuer: NUM_ITEMS=8, FLUSH_AT=6, PIPE_DEPTH=3.
// Starts push the expected beat stream; a negedge monitor pops on each accept or flush.

module tb_dual_lane_issuer;

    localparam logic [31:0] BASE1 = 32'h1000_0000;
    localparam logic [31:0] BASE2 = 32'h2000_0000;

    logic        clk, reset, start, stall_1, stall_2;
    logic [31:0] pipeline1_inputs, pipeline2_inputs;
    logic [1:0]  in_valid;
    logic        flush_1, flush_2, done;
    logic [15:0] accept_cnt_1, accept_cnt_2;

    dual_lane_issuer #(
        .DATA_W(32), .NUM_ITEMS(8), .BASE_1(BASE1), .BASE_2(BASE2),
        .FLUSH_AT(6), .PIPE_DEPTH(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall_1(stall_1), .stall_2(stall_2),
        .pipeline1_inputs(pipeline1_inputs), .pipeline2_inputs(pipeline2_inputs),
        .in_valid(in_valid), .flush_1(flush_1), .flush_2(flush_2), .done(done),
        .accept_cnt_1(accept_cnt_1), .accept_cnt_2(accept_cnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-derived run: indices 0..5 accepted, flush (-1), replay 3..7.
    int exp_seq [12] = '{0, 1, 2, 3, 4, 5, -1, 3, 4, 5, 6, 7};
    int q1[$];
    int q2[$];
    int last_cyc [2];
    logic        prev_v  [2];
    logic        prev_st [2];
    logic [31:0] prev_d  [2];
    logic        prev_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_run();
        for (int i = 0; i < 12; i++) begin
            q1.push_back(exp_seq[i]);
            q2.push_back(exp_seq[i]);
        end
    endtask

    task automatic mon_lane(input int k, input logic v, input logic st, input logic fl,
                            input logic [31:0] d, input logic [31:0] base);
        int e;
        int sz;
        if (prev_v[k] && prev_st[k]) begin
            chk($sformatf("hold_valid_l%0d", k + 1), {63'd0, v}, 64'd1);
            chk($sformatf("hold_data_l%0d", k + 1), {32'd0, d}, {32'd0, prev_d[k]});
        end
        if (fl || (v && !st)) begin
            sz = (k == 0) ? q1.size() : q2.size();
            if (sz == 0) begin
                chk($sformatf("unexpected_beat_l%0d", k + 1), {32'd0, d}, 64'd0);
            end else begin
                e = (k == 0) ? q1.pop_front() : q2.pop_front();
                if (fl) begin
                    chk($sformatf("flush_expected_l%0d", k + 1), 64'(e), 64'(-1));
                    chk($sformatf("flush_valid_low_l%0d", k + 1), {63'd0, v}, 64'd0);
                end else begin
                    chk($sformatf("beat_data_l%0d", k + 1), {32'd0, d},
                        (e < 0) ? 64'hDEAD : {32'd0, base + 32'(e)});
                end
                if (sz == 1) last_cyc[k] = cyc;
            end
        end
        prev_v[k]  = v;
        prev_st[k] = st;
        prev_d[k]  = d;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_v[0] = 1'b0; prev_v[1] = 1'b0;
            prev_st[0] = 1'b0; prev_st[1] = 1'b0;
            prev_done = 1'b0;
        end else begin
            mon_lane(0, in_valid[0], stall_1, flush_1, pipeline1_inputs, BASE1);
            mon_lane(1, in_valid[1], stall_2, flush_2, pipeline2_inputs, BASE2);
            if (done && !prev_done)
                chk("done_timing", 64'(cyc),
                    64'(((last_cyc[0] > last_cyc[1]) ? last_cyc[0] : last_cyc[1]) + 1));
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, {62'd0, in_valid}, 64'd0);
        chk({nm, "_data"}, {pipeline1_inputs, pipeline2_inputs}, 64'd0);
        chk({nm, "_flags"}, {61'd0, flush_1, flush_2, done}, 64'd0);
        chk({nm, "_cnts"}, {32'd0, accept_cnt_1, accept_cnt_2}, 64'd0);
    endtask

    task automatic start_run();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_valid", {62'd0, in_valid}, 64'd3);
        chk("first_data", {pipeline1_inputs, pipeline2_inputs}, {BASE1, BASE2});
        chk("first_cnts", {32'd0, accept_cnt_1, accept_cnt_2}, 64'd0);
        chk("first_flags", {61'd0, flush_1, flush_2, done}, 64'd0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            tick();
            t++;
        end
        chk("done_reached", {63'd0, done}, 64'd1);
        chk("end_cnt_1", 64'(accept_cnt_1), 64'd11);
        chk("end_cnt_2", 64'(accept_cnt_2), 64'd11);
        chk("scoreboard_empty", 64'(q1.size() + q2.size()), 64'd0);
        chk("end_valid_low", {62'd0, in_valid}, 64'd0);
    endtask

    initial begin
        int t;
        reset = 1'b0; start = 1'b0; stall_1 = 1'b0; stall_2 = 1'b0;
        #1;
        chk_all_zero("reset_state");
        tick(); tick();
        reset = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_no_start", {62'd0, in_valid}, 64'd0);
        end

        // Run 1: no stall.
        start_run();
        wait_done();
        chk("lane_skew_nostall", 64'(last_cyc[0] - last_cyc[1]), 64'd0);

        // Run 2: stall lane 1 for 3 cycles on index 2.
        start_run();
        t = 0;
        while (!(in_valid[0] && pipeline1_inputs == BASE1 + 32'd2) && t < 20) begin
            tick();
            t++;
        end
        chk("seq2_seen", {63'd0, in_valid[0]}, 64'd1);
        stall_1 = 1'b1;
        repeat (3) tick();
        stall_1 = 1'b0;
        wait_done();
        chk("lane1_late_by_3", 64'(last_cyc[0] - last_cyc[1]), 64'd3);

        // Run 3: stall lane 2 across its flush cycle, and a mid-run start that must be ignored.
        start_run();
        t = 0;
        while (!flush_2 && t < 20) begin
            tick();
            t++;
        end
        chk("flush2_seen", {63'd0, flush_2}, 64'd1);
        stall_2 = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            chk("replay_held_flush", {63'd0, flush_2}, 64'd0);
            chk("replay_held_data", {31'd0, in_valid[1], pipeline2_inputs}, {31'd0, 1'b1, BASE2 + 32'd3});
            chk("replay_held_cnt", 64'(accept_cnt_2), 64'd6);
            tick();
        end
        stall_2 = 1'b0;
        wait_done();

        // Run 4: reset mid-stream, then restart from scratch.
        start_run();
        repeat (3) tick();
        #2;
        reset = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk_all_zero("midrun_reset");
        tick(); tick();
        reset = 1'b1;
        repeat (2) begin
            tick();
            chk("post_reset_idle", {62'd0, in_valid}, 64'd0);
        end
        start_run();
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
